// File: rtl/mem_master.sv
// Valid/ready SRAM initiator: command FIFO, one-at-a-time request issue, one response per command.
// Optional REQ watchdog enabled by defining MEM_MASTER_TIMEOUT_EN.
module mem_master #(
  parameter int ADDR_WIDTH = 3,
  parameter int WIDTH      = 8,
  parameter int FIFO_AW    = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_wr,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  mem_valid,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic                  mem_ready,
  input  logic [WIDTH-1:0]      mem_rdata
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = DEPTH[FIFO_AW:0];

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  cmd_t               fifo_q [DEPTH];
  cmd_t               head;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q;
  state_t             state_q, state_d;
  logic               push, pop, empty, full, done, tmo_hit;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = fifo_q[rptr_q];

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= cmd_t'{cmd_wr, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (FIFO_AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (FIFO_AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef MEM_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q;

  assign tmo_hit = (state_q == REQ) && !mem_ready && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                tmo_q <= '0;
    else if (pop)            tmo_q <= '0;
    else if (state_q == REQ) tmo_q <= tmo_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rsp_err <= 1'b0;
    else if (done)    rsp_err <= 1'b0;
    else if (tmo_hit) rsp_err <= 1'b1;
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT;
  assign tmo_hit    = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Pops only while mem_ready is low: the responder's trailing ready must clear first.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (!empty && !mem_ready) begin
        pop     = 1'b1;
        state_d = REQ;
      end
      REQ: if (mem_ready) begin
        done    = 1'b1;
        state_d = DRAIN;
      end else if (tmo_hit) begin
        state_d = DRAIN;
      end
      DRAIN: if (!mem_ready) begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (pop) begin
        mem_valid <= 1'b1;
        mem_wr_en <= head.wr;
        mem_addr  <= head.addr;
        mem_wdata <= head.wdata;
      end
      if (done || tmo_hit) begin
        mem_valid <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_wr    <= mem_wr_en;
        rsp_data  <= (done && !mem_wr_en) ? mem_rdata : '0;
      end
    end
  end
endmodule
